// File: rtl/result_bus_arbiter.sv
// rtl/result_bus_arbiter.sv - round-robin grant of result buses to finished stations
// Optional stall counter output enabled by RESULT_BUS_STALL_COUNTER_EN.
module result_bus_arbiter #(
  parameter int SIZE               = 32,
  parameter int STATION_COUNT      = 4,
  parameter int STATION_INDEX_SIZE = 2,
  parameter int BUS_COUNT          = 1
) (
  input  logic                          clock,
  input  logic                          reset,
  input  logic                          flush,
  input  logic                          request       [0:STATION_COUNT-1],
  input  logic [SIZE-1:0]               request_value [0:STATION_COUNT-1],
  output logic                          grant         [0:STATION_COUNT-1],
  output logic                          bus_asserted  [0:BUS_COUNT-1],
  output logic [STATION_INDEX_SIZE-1:0] bus_source    [0:BUS_COUNT-1],
  output logic [SIZE-1:0]               bus_value     [0:BUS_COUNT-1]
`ifdef RESULT_BUS_STALL_COUNTER_EN
  ,
  output logic [31:0]                   stall_cycles
`endif
);

  logic [STATION_INDEX_SIZE-1:0] ptr;
  logic [STATION_INDEX_SIZE-1:0] next_ptr;
  logic                          any_grant;
  logic                          bus_hit [0:BUS_COUNT-1];
  logic [STATION_INDEX_SIZE-1:0] bus_sel [0:BUS_COUNT-1];
  int                            idx;
  int                            n;

  // Scan from ptr with explicit wrap so non-power-of-two station counts never index past the end.
  always_comb begin
    any_grant = 1'b0;
    next_ptr  = ptr;
    idx       = 0;
    n         = 0;
    for (int s = 0; s < STATION_COUNT; s++) grant[s] = 1'b0;
    for (int b = 0; b < BUS_COUNT; b++) begin
      bus_hit[b] = 1'b0;
      bus_sel[b] = '0;
    end
    if (reset && !flush) begin
      for (int i = 0; i < STATION_COUNT; i++) begin
        idx = int'(ptr) + i;
        if (idx >= STATION_COUNT) idx = idx - STATION_COUNT;
        if (request[idx] && n < BUS_COUNT) begin
          grant[idx] = 1'b1;
          bus_hit[n] = 1'b1;
          bus_sel[n] = STATION_INDEX_SIZE'(idx);
          any_grant  = 1'b1;
          next_ptr   = (idx == STATION_COUNT - 1) ? '0 : STATION_INDEX_SIZE'(idx + 1);
          n          = n + 1;
        end
      end
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      ptr <= '0;
      for (int b = 0; b < BUS_COUNT; b++) begin
        bus_asserted[b] <= 1'b0;
        bus_source[b]   <= '0;
        bus_value[b]    <= '0;
      end
    end else begin
      for (int b = 0; b < BUS_COUNT; b++) begin
        bus_asserted[b] <= bus_hit[b];
        if (bus_hit[b]) begin
          bus_source[b] <= bus_sel[b];
          bus_value[b]  <= request_value[bus_sel[b]];
        end
      end
      if (any_grant) ptr <= next_ptr;
    end
  end

`ifdef RESULT_BUS_STALL_COUNTER_EN
  logic stalled;

  always_comb begin
    stalled = 1'b0;
    for (int s = 0; s < STATION_COUNT; s++)
      if (request[s] && !grant[s]) stalled = 1'b1;
  end

  always_ff @(posedge clock) begin
    if (!reset)
      stall_cycles <= '0;
    else if (stalled && stall_cycles != 32'hFFFF_FFFF)
      stall_cycles <= stall_cycles + 32'd1;
  end
`endif

endmodule

// File: tb/tb_result_bus_arbiter.sv
// tb/tb_result_bus_arbiter.sv - directed vector bench for result_bus_arbiter
module tb_result_bus_arbiter;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic rst;
  logic fl;

  logic        req1 [0:3];
  logic [31:0] val1 [0:3];
  logic        gnt1 [0:3];
  logic        ba1  [0:0];
  logic [1:0]  bs1  [0:0];
  logic [31:0] bv1  [0:0];

  logic        req2 [0:3];
  logic [31:0] val2 [0:3];
  logic        gnt2 [0:3];
  logic        ba2  [0:1];
  logic [1:0]  bs2  [0:1];
  logic [31:0] bv2  [0:1];

  logic        req3 [0:2];
  logic [31:0] val3 [0:2];
  logic        gnt3 [0:2];
  logic        ba3  [0:0];
  logic [1:0]  bs3  [0:0];
  logic [31:0] bv3  [0:0];

`ifdef RESULT_BUS_STALL_COUNTER_EN
  logic [31:0] st1, st2, st3;
`endif

  result_bus_arbiter #(.SIZE(32), .STATION_COUNT(4), .STATION_INDEX_SIZE(2), .BUS_COUNT(1)) dut1 (
    .clock(clock), .reset(rst), .flush(fl), .request(req1), .request_value(val1),
    .grant(gnt1), .bus_asserted(ba1), .bus_source(bs1), .bus_value(bv1)
`ifdef RESULT_BUS_STALL_COUNTER_EN
    , .stall_cycles(st1)
`endif
  );

  result_bus_arbiter #(.SIZE(32), .STATION_COUNT(4), .STATION_INDEX_SIZE(2), .BUS_COUNT(2)) dut2 (
    .clock(clock), .reset(rst), .flush(fl), .request(req2), .request_value(val2),
    .grant(gnt2), .bus_asserted(ba2), .bus_source(bs2), .bus_value(bv2)
`ifdef RESULT_BUS_STALL_COUNTER_EN
    , .stall_cycles(st2)
`endif
  );

  result_bus_arbiter #(.SIZE(32), .STATION_COUNT(3), .STATION_INDEX_SIZE(2), .BUS_COUNT(1)) dut3 (
    .clock(clock), .reset(rst), .flush(fl), .request(req3), .request_value(val3),
    .grant(gnt3), .bus_asserted(ba3), .bus_source(bs3), .bus_value(bv3)
`ifdef RESULT_BUS_STALL_COUNTER_EN
    , .stall_cycles(st3)
`endif
  );

  typedef struct {
    logic        rst;
    logic        fl;
    logic [3:0]  req;
    logic [3:0]  g;
    logic        chk_bus;
    logic        a;
    logic [1:0]  src;
    logic [31:0] val;
  } vec_t;

  vec_t vt [0:13];
  int   total = 0;
  int   passed = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  function automatic logic [3:0] pack1();
    logic [3:0] g;
    for (int i = 0; i < 4; i++) g[i] = gnt1[i];
    return g;
  endfunction

  function automatic logic [3:0] pack2();
    logic [3:0] g;
    for (int i = 0; i < 4; i++) g[i] = gnt2[i];
    return g;
  endfunction

  function automatic logic [3:0] pack3();
    logic [3:0] g;
    g[3] = 1'b0;
    for (int i = 0; i < 3; i++) g[i] = gnt3[i];
    return g;
  endfunction

  task automatic set2(input logic [3:0] r);
    for (int i = 0; i < 4; i++) req2[i] = r[i];
  endtask

  task automatic set3(input logic [2:0] r);
    for (int i = 0; i < 3; i++) req3[i] = r[i];
  endtask

  initial begin
    // bus fields give the bus contents registered at the previous edge
    vt[0]  = '{1'b0, 1'b0, 4'b1111, 4'b0000, 1'b0, 1'b0, 2'd0, 32'h00};
    vt[1]  = '{1'b0, 1'b0, 4'b1111, 4'b0000, 1'b1, 1'b0, 2'd0, 32'h00};
    vt[2]  = '{1'b1, 1'b0, 4'b1111, 4'b0001, 1'b1, 1'b0, 2'd0, 32'h00};
    vt[3]  = '{1'b1, 1'b0, 4'b0101, 4'b0100, 1'b1, 1'b1, 2'd0, 32'hA0};
    vt[4]  = '{1'b1, 1'b0, 4'b0101, 4'b0001, 1'b1, 1'b1, 2'd2, 32'hA2};
    vt[5]  = '{1'b1, 1'b0, 4'b0101, 4'b0100, 1'b1, 1'b1, 2'd0, 32'hA0};
    vt[6]  = '{1'b1, 1'b0, 4'b0000, 4'b0000, 1'b1, 1'b1, 2'd2, 32'hA2};
    vt[7]  = '{1'b1, 1'b0, 4'b0010, 4'b0010, 1'b1, 1'b0, 2'd2, 32'hA2};
    vt[8]  = '{1'b1, 1'b1, 4'b1000, 4'b0000, 1'b1, 1'b1, 2'd1, 32'hA1};
    vt[9]  = '{1'b1, 1'b0, 4'b1000, 4'b1000, 1'b1, 1'b0, 2'd1, 32'hA1};
    vt[10] = '{1'b1, 1'b0, 4'b0000, 4'b0000, 1'b1, 1'b1, 2'd3, 32'hA3};
    vt[11] = '{1'b1, 1'b0, 4'b0100, 4'b0100, 1'b1, 1'b0, 2'd3, 32'hA3};
    vt[12] = '{1'b0, 1'b0, 4'b1111, 4'b0000, 1'b1, 1'b1, 2'd2, 32'hA2};
    vt[13] = '{1'b1, 1'b0, 4'b1111, 4'b0001, 1'b1, 1'b0, 2'd0, 32'h00};

    for (int i = 0; i < 4; i++) begin
      req1[i] = 1'b0;
      req2[i] = 1'b0;
      val1[i] = 32'hA0 + 32'(i);
      val2[i] = 32'hB0 + 32'(i);
    end
    for (int i = 0; i < 3; i++) begin
      req3[i] = 1'b0;
      val3[i] = 32'hC0 + 32'(i);
    end
    rst = 1'b0;
    fl  = 1'b0;

    for (int k = 0; k < 14; k++) begin
      @(negedge clock);
      rst = vt[k].rst;
      fl  = vt[k].fl;
      for (int i = 0; i < 4; i++) req1[i] = vt[k].req[i];
      #1;
      chk($sformatf("v%0d grant", k), 32'(pack1()), 32'(vt[k].g));
      if (vt[k].chk_bus) begin
        chk($sformatf("v%0d asserted", k), 32'(ba1[0]), 32'(vt[k].a));
        chk($sformatf("v%0d source", k), 32'(bs1[0]), 32'(vt[k].src));
        chk($sformatf("v%0d value", k), bv1[0], vt[k].val);
      end
    end
    @(negedge clock);
    for (int i = 0; i < 4; i++) req1[i] = 1'b0;

`ifdef RESULT_BUS_STALL_COUNTER_EN
    rst = 1'b0;
    @(negedge clock);
    rst = 1'b1;
    for (int i = 0; i < 3; i++) req1[i] = 1'b1;
    #1 chk("stall after reset", st1, 32'd0);
    for (int c = 0; c < 4; c++) @(negedge clock);
    #1 chk("stall after 4", st1, 32'd4);
    rst = 1'b0;
    for (int i = 0; i < 4; i++) req1[i] = 1'b0;
    @(negedge clock);
    rst = 1'b1;
    #1 chk("stall cleared", st1, 32'd0);
`endif

    // two buses, ptr steered to 3 first
    @(negedge clock);
    set2(4'b0100);
    #1 chk("m1 grant", 32'(pack2()), 32'b0100);
    @(negedge clock);
    set2(4'b1110);
    #1 chk("m2 grant", 32'(pack2()), 32'b1010);
    chk("m2 bus0 a", 32'(ba2[0]), 32'd1);
    chk("m2 bus0 src", 32'(bs2[0]), 32'd2);
    chk("m2 bus1 a", 32'(ba2[1]), 32'd0);
    @(negedge clock);
    set2(4'b0100);
    #1 chk("m3 grant", 32'(pack2()), 32'b0100);
    chk("m3 bus0 src", 32'(bs2[0]), 32'd3);
    chk("m3 bus0 val", bv2[0], 32'hB3);
    chk("m3 bus1 a", 32'(ba2[1]), 32'd1);
    chk("m3 bus1 src", 32'(bs2[1]), 32'd1);
    chk("m3 bus1 val", bv2[1], 32'hB1);
    @(negedge clock);
    set2(4'b0000);
    #1 chk("m4 bus0 src", 32'(bs2[0]), 32'd2);
    chk("m4 bus0 val", bv2[0], 32'hB2);
    chk("m4 bus1 a", 32'(ba2[1]), 32'd0);
    chk("m4 bus1 val held", bv2[1], 32'hB1);

    // three stations: pointer must wrap 2 -> 0
    @(negedge clock);
    set3(3'b100);
    #1 chk("w1 grant", 32'(pack3()), 32'b100);
    @(negedge clock);
    set3(3'b011);
    #1 chk("w2 grant", 32'(pack3()), 32'b001);
    chk("w2 src", 32'(bs3[0]), 32'd2);
    chk("w2 val", bv3[0], 32'hC2);
    @(negedge clock);
    set3(3'b010);
    #1 chk("w3 grant", 32'(pack3()), 32'b010);
    chk("w3 src", 32'(bs3[0]), 32'd0);
    @(negedge clock);
    set3(3'b000);
    #1 chk("w4 a", 32'(ba3[0]), 32'd1);
    chk("w4 src", 32'(bs3[0]), 32'd1);
    chk("w4 val", bv3[0], 32'hC1);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/result_bus_arbiter.md
Name: result_bus_arbiter

Overview:
- Shares the BUS_COUNT result (common data) buses among STATION_COUNT execution stations that hold completed results.
- Each cycle, grants up to BUS_COUNT requesting stations in round-robin order and drives the registered bus_asserted/bus_source/bus_value arrays.
- Those arrays are the ones every reservation-station operand slot snoops to capture pending operands.
- Sits between the functional-unit result holders and the reservation stations / register status table.

Parameters:
- SIZE, 32, result value width.
- STATION_COUNT, 4, number of requesting stations; station i is tagged with index i.
- STATION_INDEX_SIZE, 2, tag width; STATION_COUNT <= 2**STATION_INDEX_SIZE.
- BUS_COUNT, 1, number of result buses; 1 <= BUS_COUNT <= STATION_COUNT.

Ports:
- clock  input  1  sole clock, rising edge.
- reset  input  1  one clock; reset is synchronous and active-low (0 = reset).
- flush  input  1  pipeline flush; suppresses grants this cycle and clears bus outputs.
- request[0:STATION_COUNT-1]  input  1 each  station i holds a finished result.
- request_value[0:STATION_COUNT-1]  input  SIZE each  result of station i, stable while request[i]=1.
- grant[0:STATION_COUNT-1]  output  1 each  combinational; station i wins a bus this cycle.
- bus_asserted[0:BUS_COUNT-1]  output  1 each  bus b carries a valid result.
- bus_source[0:BUS_COUNT-1]  output  STATION_INDEX_SIZE each  tag of the producing station.
- bus_value[0:BUS_COUNT-1]  output  SIZE each  result value.

Behaviour:
- State: round-robin pointer ptr (STATION_INDEX_SIZE bits, range 0..STATION_COUNT-1) plus the registered bus outputs.
- Reset (reset=0 at a rising edge): ptr=0; all bus_asserted=0, bus_source=0, bus_value=0.
- While reset=0, grant is forced to all-zero.
- Grant selection (combinational):
  - Scan stations ptr, ptr+1, ... modulo STATION_COUNT.
  - The first BUS_COUNT stations with request=1 are granted, in scan order.
  - The k-th granted station in scan order maps to bus k.
  - grant=0 for every station when flush=1 or reset=0.
- Handshake:
  - A station keeps request high and request_value stable until it sees grant=1 at a rising edge.
  - It deasserts request in the following cycle, or raises it again with a new value.
  - A request withdrawn before being granted is legal and is simply not granted.
- Bus latency: 1 cycle. At the edge where station s is granted onto bus k, register bus_asserted[k]=1, bus_source[k]=s, bus_value[k]=request_value[s].
- Unused buses: buses with no grant this cycle register bus_asserted=0 and hold their previous source/value.
- Pointer update:
  - If at least one grant occurred, ptr <= (last granted index + 1) mod STATION_COUNT.
  - Otherwise ptr holds.
  - Wrap from STATION_COUNT-1 to 0 is required even when STATION_COUNT is not a power of two.
- Flush: at that edge all bus_asserted <= 0 and ptr holds. A flush in the cycle after a grant still clears the already-registered bus entries.
- No requests: no grants, all bus_asserted <= 0, ptr holds.
- Fewer requests than buses: every requester is granted in the same cycle; the higher-numbered buses are idle.
- A given station tag never appears on two buses in the same cycle.
- Reset mid-operation: pending grants are lost; requesters re-arbitrate from ptr=0 after reset releases.

Optional Feature:
- Macro: RESULT_BUS_STALL_COUNTER_EN.
- With the macro defined:
  - Extra output stall_cycles [31:0].
  - Increments by 1 on each edge where at least one request=1 was not granted, flush cycles included.
  - Saturates at 32'hFFFFFFFF.
  - Cleared to 0 by reset.
- Without the macro: the port and counter do not exist; all other behaviour is identical.

Test Plan:
- Reset: hold reset=0 for 2 cycles with all requests=1 -> grant all 0; bus_asserted all 0, source/value 0. After release with BUS_COUNT=1, first grant goes to station 0.
- Round-robin (BUS_COUNT=1): requests 0 and 2 held continuously, values 0xA0 and 0xA2 -> buses show source 0/0xA0, then 2/0xA2, then 0/0xA0, alternating each cycle one cycle after each grant.
- Multi-bus (BUS_COUNT=2, ptr=3): requests on stations 1, 2, 3 -> grant 3 and 1; bus0 gets source 3, bus1 gets source 1; ptr becomes 2; next cycle station 2 is granted onto bus0 and bus1 is deasserted.
- Wrap (STATION_COUNT=3, STATION_INDEX_SIZE=2, BUS_COUNT=1): single request from station 2 -> granted, ptr becomes 0 (never 3); a following request from station 0 is granted.
- Flush: station 1 granted at cycle N, flush=1 at cycle N+1 with station 3 requesting -> bus_asserted[0]=1 (source 1) in cycle N+1; bus_asserted=0 in cycle N+2; station 3 is not granted in cycle N+1 and is granted in cycle N+2.
- Stall counter (macro on, BUS_COUNT=1): 3 stations request for 4 cycles -> stall_cycles=4; reset=0 for 1 cycle -> 0.
